// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a show-ahead RX FIFO for the core's memory-mapped read port.
// Optional: define UART_RX_PARITY_EN for 8E1 frames with a parity_err flag.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       uart_rdreq,
    input  logic       err_clr,
    output logic [7:0] uart_in,
    output logic       uart_empty,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          rxd_meta, rxd_sync;
    logic          push_req, push_n, frame_ev;
`ifdef UART_RX_PARITY_EN
    logic          par_bit, par_bit_n, parity_ev, parity_q;
`endif

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
    logic                  fifo_full, do_pop, do_push, overrun_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            push_req <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            push_req <= push_n;
`ifdef UART_RX_PARITY_EN
            par_bit  <= par_bit_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push_n    = 1'b0;
        frame_ev  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
        parity_ev = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxd_sync) begin
                    cnt_n   = HALF_BIT;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    cnt_n     = FULL_BIT;
                    bit_idx_n = '0;
                    state_n   = rxd_sync ? IDLE : DATA;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_n     = FULL_BIT;
                    shreg_n   = {rxd_sync, shreg[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == '0) begin
                    cnt_n     = FULL_BIT;
                    par_bit_n = rxd_sync;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (cnt == '0) begin
                    state_n   = IDLE;
                    frame_ev  = !rxd_sync;
`ifdef UART_RX_PARITY_EN
                    parity_ev = ^{shreg, par_bit};
                    push_n    = rxd_sync && !parity_ev;
`else
                    push_n    = rxd_sync;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign uart_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                        (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop     = uart_rdreq && !uart_empty;
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign overrun_ev = push_req && fifo_full && !do_pop;
    assign uart_in    = uart_empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    // shreg is stable during the push cycle, so it doubles as the write data.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            overrun   <= overrun_ev | (overrun & ~err_clr);
            frame_err <= frame_ev | (frame_err & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_q <= 1'b0;
        else
            parity_q <= parity_ev | (parity_q & ~err_clr);
    end
    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, corner sequences and random frames vs a queue model.
module tb_uart_rx_fifo;
    localparam int CPB   = 8;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // 2 sync stages + half-bit start wait + remaining bits, then push one cycle after stop sample.
    localparam int PUSH_OFF  = 3 + CPB / 2 + CPB * (NB - 1);
    localparam int FRAME_CYC = CPB * NB + CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       uart_rdreq = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] uart_in;
    logic       uart_empty, overrun, frame_err, parity_err;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .uart_rdreq (uart_rdreq),
        .err_clr    (err_clr),
        .uart_in    (uart_in),
        .uart_empty (uart_empty),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic m_ovr, m_fe, m_pe;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       pop;
        logic       clr;
        logic       exp_empty;
        logic [7:0] exp_in;
        logic       exp_fe;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        m_pe  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rxd = 1'b1;
        uart_rdreq = 1'b0;
        err_clr = 1'b0;
        model_clear();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_model(input string tag);
        logic [7:0] head;
        head = 8'h00;
        if (q.size() > 0) head = q[0];
        chk({tag, ".empty"}, 32'(uart_empty), 32'(q.size() == 0));
        chk({tag, ".data"}, 32'(uart_in), 32'(head));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_pe));
    endtask

    task automatic pop_one();
        uart_rdreq = 1'b1;
        tick();
        uart_rdreq = 1'b0;
        if (q.size() > 0) q.delete(0);
    endtask

    task automatic clr_flags();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        m_pe  = 1'b0;
    endtask

    // Drives one frame; optional rdreq/err_clr pulse at a given cycle, or a reset abort.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                              input int pop_at, input int clr_at, input int abort_at);
        int b;
        logic par_ok;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                rxd = 1'b1;
                uart_rdreq = 1'b0;
                err_clr = 1'b0;
                #1;
                chk("reset_async.empty", 32'(uart_empty), 32'd1);
                chk("reset_async.data", 32'(uart_in), 32'd0);
                model_clear();
                repeat (2) tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            b = c / CPB;
            if (b == 0)              rxd = 1'b0;
            else if (b <= 8)         rxd = d[b-1];
            else if (b == NB - 1)    rxd = stop;
            else if (b == 9)         rxd = (^d) ^ par_flip;
            else                     rxd = 1'b1;
            uart_rdreq = (c == pop_at);
            err_clr    = (c == clr_at);
            tick();
        end
        uart_rdreq = 1'b0;
        err_clr = 1'b0;
        if (clr_at >= 0) begin
            m_ovr = 1'b0;
            m_fe  = 1'b0;
            m_pe  = 1'b0;
        end
        if (pop_at == PUSH_OFF && q.size() > 0) q.delete(0);
        par_ok = (NB == 10) || !par_flip;
        if (!stop) m_fe = 1'b1;
        if (!par_ok) m_pe = 1'b1;
        if (stop && par_ok) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovr = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b0};

        #1;
        chk("reset_hold.empty", 32'(uart_empty), 32'd1);
        do_reset();
        chk("reset.empty", 32'(uart_empty), 32'd1);
        chk("reset.data", 32'(uart_in), 32'd0);
        chk("reset.overrun", 32'(overrun), 32'd0);
        chk("reset.frame_err", 32'(frame_err), 32'd0);
        chk("reset.parity_err", 32'(parity_err), 32'd0);

        pop_one();
        check_model("pop_empty");

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].d, vecs[i].stop, 1'b0, -1, -1, -1);
            if (vecs[i].pop) pop_one();
            if (vecs[i].clr) clr_flags();
            chk($sformatf("vec%0d.empty", i), 32'(uart_empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d.data", i), 32'(uart_in), 32'(vecs[i].exp_in));
            chk($sformatf("vec%0d.frame_err", i), 32'(frame_err), 32'(vecs[i].exp_fe));
        end

        do_reset();
        rxd = 1'b0;
        repeat (3) tick();
        rxd = 1'b1;
        repeat (3 * CPB) tick();
        check_model("glitch");
        send_frame(8'h42, 1'b1, 1'b0, -1, -1, -1);
        check_model("after_glitch");

        do_reset();
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0, -1, -1, -1);
        chk("ovr.flag", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr.read%0d", i), 32'(uart_in), 32'(i));
            pop_one();
        end
        check_model("ovr.drained");
        chk("ovr.empty_end", 32'(uart_empty), 32'd1);
        clr_flags();
        check_model("ovr.cleared");

        do_reset();
        for (int i = 0; i < 16; i++) send_frame(8'(i + 16), 1'b1, 1'b0, -1, -1, -1);
        send_frame(8'h77, 1'b1, 1'b0, PUSH_OFF, -1, -1);
        check_model("full_pop");
        chk("full_pop.overrun", 32'(overrun), 32'd0);
        while (q.size() > 1) pop_one();
        chk("full_pop.last", 32'(uart_in), 32'h77);
        pop_one();
        check_model("full_pop.end");

        send_frame(8'hA5, 1'b0, 1'b0, -1, PUSH_OFF - 1, -1);
        chk("fe_beats_clr", 32'(frame_err), 32'd1);
        check_model("fe_beats_clr");
        do_reset();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0, -1, -1, -1);
        send_frame(8'hEE, 1'b1, 1'b0, -1, PUSH_OFF, -1);
        chk("ovr_beats_clr", 32'(overrun), 32'd1);
        check_model("ovr_beats_clr");

        do_reset();
        send_frame(8'h11, 1'b1, 1'b0, -1, -1, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1, -1, CPB * 5 + 3);
        repeat (2 * CPB) tick();
        check_model("abort.idle");
        send_frame(8'h3C, 1'b1, 1'b0, -1, -1, -1);
        chk("abort.byte", 32'(uart_in), 32'h3C);
        pop_one();
        check_model("abort.single");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1, -1);
        chk("parity.flag", 32'(parity_err), 32'd1);
        check_model("parity");
        clr_flags();
`endif

        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [7:0] d;
            logic stop, pf;
            int pop_at;
            d = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pf = ($urandom_range(0, 7) == 0);
            pop_at = ($urandom_range(0, 3) == 0) ? PUSH_OFF : -1;
            send_frame(d, stop, pf, pop_at, -1, -1);
            check_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) begin
                pop_one();
                check_model($sformatf("rnd%0d.pop", i));
            end
            if ($urandom_range(0, 9) == 0) clr_flags();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
